// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by the execute-stage hazard logic.
//
// Contents:
//   DATA_W        operand width of the compare datapath
//   OP_W          opcode width
//   OP_BEQ/OP_BGT branch opcodes
//   is_branch_op  1 when an opcode is one of the branch opcodes above
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] OP_BEQ = 5'b01000;
    localparam logic [OP_W-1:0] OP_BGT = 5'b01001;

    // New branch types must be added here and in branch_comparator together.
    function automatic logic is_branch_op(input logic [OP_W-1:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_BEQ:  hit = 1'b1;
            OP_BGT:  hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage : pipeline_pkg

// File: rtl/ctrl_hazard_unit_branch_comparator.sv
// Branch condition evaluator for the instruction in E.
//
// Ports:
//   opCode  in   OP_W    opcode of the instruction in E
//   opeA    in   DATA_W  first operand (already forwarded)
//   opeB    in   DATA_W  second operand (already forwarded)
//   cond    out  1       branch condition for the opcode; 0 for non-branch opcodes
//
// Purely combinational. Kept apart from the taken logic so that more branch
// types only touch this file and the package.
module branch_comparator
    import pipeline_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int OP_W_P   = OP_W
) (
    input  logic [OP_W_P-1:0]   opCode,
    input  logic [DATA_W_P-1:0] opeA,
    input  logic [DATA_W_P-1:0] opeB,
    output logic                cond
);

    logic eq;
    logic gt_signed;

    // Full-width compares; equality is bitwise, greater-than is two's complement.
    assign eq        = (opeA == opeB);
    assign gt_signed = ($signed(opeA) > $signed(opeB));

    always_comb begin
        cond = 1'b0;
        case (opCode)
            OP_BEQ:  cond = eq;
            OP_BGT:  cond = gt_signed;
            default: cond = 1'b0;
        endcase
    end

endmodule : branch_comparator

// File: rtl/ctrl_hazard_unit.sv
// Execute-stage control-hazard resolver.
//
// When a branch in E resolves taken, the PC mux is redirected to the branch
// target and the wrong-path instructions in IF/ID and ID/EX are flushed in the
// same cycle. The following cycle the fetch stage is stalled while the
// synchronous instruction memory returns the target instruction.
//
// Ports:
//   clk        in   1       pipeline clock, rising edge
//   rst_n      in   1       synchronous active-low reset
//   branchE    in   1       instruction in E is a branch
//   opCode     in   OP_W    opcode of the instruction in E
//   opeA       in   DATA_W  first compare operand (forwarded)
//   opeB       in   DATA_W  second compare operand (forwarded)
//   select_pc  out  1       1 = next PC is branch target, 0 = PC+4
//   flush      out  1       clear IF/ID and ID/EX
//   stall      out  1       hold PC and IF/ID
module ctrl_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int OP_W_P   = OP_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                branchE,
    input  logic [OP_W_P-1:0]   opCode,
    input  logic [DATA_W_P-1:0] opeA,
    input  logic [DATA_W_P-1:0] opeB,
    output logic                select_pc,
    output logic                flush,
    output logic                stall
);

    logic cond;
    logic taken;
    logic taken_d;
    logic taken_q;

    branch_comparator #(
        .DATA_W_P (DATA_W_P),
        .OP_W_P   (OP_W_P)
    ) u_branch_comparator (
        .opCode (opCode),
        .opeA   (opeA),
        .opeB   (opeB),
        .cond   (cond)
    );

    // The cycle after a redirect, the instruction in E came from the wrong
    // path and was flushed, so its branch bit is ignored (~taken_q). Gating
    // with rst_n keeps a branch during reset from redirecting the PC.
    always_comb begin
        taken   = branchE & is_branch_op(opCode[OP_W-1:0]) & cond & ~taken_q & rst_n;
        taken_d = taken;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_q <= 1'b0;
        end else begin
            taken_q <= taken_d;
        end
    end

    // stall is gated with rst_n so that it also reads 0 in the first reset
    // cycle, before the flop has had an edge to clear.
    assign select_pc = taken;
    assign flush     = taken;
    assign stall     = taken_q & rst_n;

endmodule : ctrl_hazard_unit

// File: tb/tb_ctrl_hazard_unit.sv
// Directed testbench for ctrl_hazard_unit.
// Inputs change just after the falling edge; outputs are checked 1 time unit
// later, well away from the rising edge that updates taken_q.
module tb_ctrl_hazard_unit;

    localparam logic [4:0] BEQ = 5'b01000;
    localparam logic [4:0] BGT = 5'b01001;
    localparam logic [4:0] ADD = 5'b00101;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst_n;
    logic        branchE;
    logic [4:0]  opCode;
    logic [31:0] opeA;
    logic [31:0] opeB;
    logic        select_pc;
    logic        flush;
    logic        stall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctrl_hazard_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .branchE   (branchE),
        .opCode    (opCode),
        .opeA      (opeA),
        .opeB      (opeB),
        .select_pc (select_pc),
        .flush     (flush),
        .stall     (stall)
    );

    // driver: advance one cycle, apply inputs, let combinational logic settle
    task automatic drive(input logic r, input logic b, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] bb);
        @(negedge clk);
        rst_n   = r;
        branchE = b;
        opCode  = op;
        opeA    = a;
        opeB    = bb;
        #1;
    endtask

    // checker: compares all three outputs against hand-computed values
    task automatic expect_out(input string tag, input logic e_sel,
                              input logic e_fl, input logic e_st);
        logic [2:0] obs;
        logic [2:0] exp_v;
        obs   = {select_pc, flush, stall};
        exp_v = {e_sel, e_fl, e_st};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: {select_pc,flush,stall} observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        branchE = 1'b0;
        opCode  = '0;
        opeA    = '0;
        opeB    = '0;

        // reset with a would-be-taken BEQ on the inputs
        drive(1'b0, 1'b1, BEQ, 32'h5c, 32'h5c);
        expect_out("reset_beq_0", 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, BEQ, 32'h5c, 32'h5c);
        expect_out("reset_beq_1", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, ADD, 32'h0, 32'h0);
        expect_out("post_reset_0", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, ADD, 32'h0, 32'h0);
        expect_out("post_reset_1", 1'b0, 1'b0, 1'b0);

        // non-branches
        drive(1'b1, 1'b0, BEQ, 32'h5c, 32'h5c);
        expect_out("nobranch_beq", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, ADD, 32'h5c, 32'h5c);
        expect_out("nonbranch_op", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, ADD, 32'h0, 32'h0);
        expect_out("nonbranch_next", 1'b0, 1'b0, 1'b0);

        // BEQ taken, then held inputs are squashed
        drive(1'b1, 1'b1, BEQ, 32'h5c, 32'h5c);
        expect_out("beq_taken", 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, BEQ, 32'h5c, 32'h5c);
        expect_out("beq_squash", 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, ADD, 32'h0, 32'h0);
        expect_out("beq_after", 1'b0, 1'b0, 1'b0);

        // BEQ not taken
        drive(1'b1, 1'b1, BEQ, 32'h55, 32'h5c);
        expect_out("beq_ne", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, BEQ, 32'hffff_005c, 32'h0000_005c);
        expect_out("beq_upper_bits", 1'b0, 1'b0, 1'b0);

        // BGT
        drive(1'b1, 1'b1, BGT, 32'h5c, 32'h5c);
        expect_out("bgt_equal", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, BGT, 32'h60, 32'h5c);
        expect_out("bgt_taken", 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, ADD, 32'h0, 32'h0);
        expect_out("bgt_stall", 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, ADD, 32'h0, 32'h0);
        expect_out("bgt_after", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, BGT, 32'h8000_0000, 32'h1);
        expect_out("bgt_neg_vs_pos", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, BGT, 32'h1, 32'h8000_0000);
        expect_out("bgt_pos_vs_neg", 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, ADD, 32'h0, 32'h0);
        expect_out("bgt_pos_stall", 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, ADD, 32'h0, 32'h0);
        expect_out("idle_a", 1'b0, 1'b0, 1'b0);

        // sustained taken condition for 4 cycles
        drive(1'b1, 1'b1, BEQ, 32'h5c, 32'h5c);
        expect_out("sustain_0", 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, BEQ, 32'h5c, 32'h5c);
        expect_out("sustain_1", 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, BEQ, 32'h5c, 32'h5c);
        expect_out("sustain_2", 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, BEQ, 32'h5c, 32'h5c);
        expect_out("sustain_3", 1'b0, 1'b0, 1'b1);

        // reset in the same cycle as a taken branch: redirect lost
        drive(1'b0, 1'b1, BEQ, 32'h5c, 32'h5c);
        expect_out("reset_on_taken", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, ADD, 32'h0, 32'h0);
        expect_out("reset_on_taken_rel", 1'b0, 1'b0, 1'b0);

        // reset arriving while stall is pending
        drive(1'b1, 1'b1, BEQ, 32'h5c, 32'h5c);
        expect_out("pre_reset_taken", 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, BEQ, 32'h5c, 32'h5c);
        expect_out("reset_during_stall", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, ADD, 32'h0, 32'h0);
        expect_out("release_after_stall", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ctrl_hazard_unit
